pipeline_hazard_ctrl: RTL and testbench

// Sequencing controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Detects load-use hazards, taken branches/jumps and data-memory wait cycles.
// - Drives per-stage write-enable and flush/bubble controls.
// - Keeps a saturating stall counter and a sticky memory-timeout error.
// - Sits beside the control unit; its outputs gate the PC and the pipeline buffers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Purpose  : Shared pipeline definitions: controller state encoding, NOP word
//            and the default register-address width.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  // Instruction word loaded into IF/ID when it is flushed
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use comparator. Flags when the load in ID/EX
//            writes a register the instruction in ID is about to read.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              lu_hazard
);

  // Register 0 is hard-wired to zero, so a load into it never creates a hazard
  always_comb begin
    lu_hazard = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Sequencing controller for the 5-stage pipeline. Decodes memory
//            wait, taken branch, jump and load-use into per-stage write
//            enables and flush/bubble controls; keeps a saturating stall
//            counter and a sticky memory-timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = pipeline_hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_we,
  output logic              idex_bubble,
  output logic              exmem_we,
  output logic              exmem_flush,
  output logic              memwb_we,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err_timeout,
  output logic [1:0]        state
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               err_timeout_q, err_timeout_d;
  logic               lu_hazard;
  logic               mem_wait;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu_hazard   (lu_hazard)
  );

  // Once the timeout error is latched the whole pipeline stays frozen
  assign mem_wait = err_timeout_q || (mem_req && !mem_ready);

  // Prioritised decode: mem wait > branch > jump > load-use; next state and counters
  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_we       = 1'b1;
    idex_bubble   = 1'b0;
    exmem_we      = 1'b1;
    exmem_flush   = 1'b0;
    memwb_we      = 1'b1;
    state_d       = ST_RUN;
    wait_cnt_d    = '0;
    err_timeout_d = err_timeout_q;

    if (mem_wait) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
      state_d  = ST_MEM_WAIT;
      if (err_timeout_q) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) begin
          err_timeout_d = 1'b1;
        end
      end
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (state_q != ST_LU_STALL) begin
      // The stall cycle itself ignores jump/load-use: the load has moved to MEM
      if (id_jump) begin
        ifid_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        state_d     = ST_LU_STALL;
      end
    end

    // Buffers load normally while reset is held
    if (!rst_n) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_bubble = 1'b0;
      exmem_we    = 1'b1;
      exmem_flush = 1'b0;
      memwb_we    = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, wait counter, stall counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign err_timeout = err_timeout_q;
  assign state       = state_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed scenarios
//            and random stimulus against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 0, id_jump = 0, ex_mem_read = 0;
  logic        mem_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic        exmem_we, exmem_flush, memwb_we, err_timeout;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_err   = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
    .exmem_we(exmem_we), .exmem_flush(exmem_flush), .memwb_we(memwb_we),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_loaduse();
    return ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  // Classify the cycle: 0 reset, 1 wait, 2 branch, 3 jump, 4 load-use, 5 normal
  function automatic int m_kind();
    if (!rst_n) return 0;
    if (m_err || (mem_req && !mem_ready)) return 1;
    if (mem_branch_taken) return 2;
    if (m_state == 1) return 5;
    if (id_jump) return 3;
    if (m_loaduse()) return 4;
    return 5;
  endfunction

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_flush, memwb_we}
  function automatic logic [7:0] m_outs();
    case (m_kind())
      1:       return 8'b0000_0000;
      2:       return 8'b1111_1111;
      3:       return 8'b1111_0101;
      4:       return 8'b0001_1101;
      default: return 8'b1101_0101;
    endcase
  endfunction

  task automatic m_advance();
    int k;
    k = m_kind();
    if (!m_outs()[7] && m_stall < 65535) m_stall++;
    if (k == 1) begin
      m_state = 2;
      if (!m_err) begin
        m_wait++;
        if (m_wait >= 15) m_err = 1;
      end
    end else begin
      m_wait  = 0;
      m_state = (k == 4) ? 1 : 0;
    end
  endtask

  // Called at posedge+1; checks mid-cycle then advances across the next edge
  task automatic step(input bit do_check);
    #3;
    if (do_check) begin
      chk("outs", {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
                   exmem_we, exmem_flush, memwb_we}, m_outs());
      chk("state", state, m_state);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("err_timeout", err_timeout, m_err);
    end
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; mem_branch_taken = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_stall = 0; m_err = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset with a load-use pattern present: enables must still be 1
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    @(posedge clk); #1;
    step(1);
    step(1);
    rst_n = 1'b1;

    // Load-use on rs: one stall cycle then RUN
    step(1);
    step(1);
    idle_inputs();
    step(1);
    chk("lu_stall_cnt", stall_cnt, 16'd1);

    // rt == 0 never hazards; rt match without id_uses_rt does not stall
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    step(1);
    ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 0;
    step(1);
    id_uses_rt = 1;
    step(1);
    step(1);

    // Branch and load-use together: branch wins, no stall counted
    idle_inputs();
    ex_mem_read = 1; ex_rt = 4; id_rs = 4; mem_branch_taken = 1;
    step(1);
    idle_inputs();
    id_jump = 1;
    step(1);

    // Three wait cycles then ready
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    repeat (3) step(1);
    chk("wait_state", state, 32'd2);
    mem_ready = 1;
    step(1);
    chk("wait_stall_cnt", stall_cnt, 16'd5);
    chk("wait_back_run", state, 32'd0);

    // Timeout: 16 cycles of not-ready latches err_timeout
    mem_ready = 0;
    repeat (16) step(1);
    mem_ready = 1;
    step(1);
    step(1);
    chk("err_sticky", err_timeout, 32'd1);

    // Async reset mid-wait
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 32'd0);
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_err", err_timeout, 32'd0);
    chk("arst_pc_we", pc_we, 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();

    // Random stimulus with small register ranges to provoke hazards
    for (int i = 0; i < 600; i++) begin
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      ex_rt            = 5'($urandom_range(0, 3));
      id_uses_rt       = 1'($urandom_range(0, 1));
      ex_mem_read      = ($urandom_range(0, 99) < 50);
      id_jump          = ($urandom_range(0, 99) < 15);
      mem_branch_taken = ($urandom_range(0, 99) < 15);
      mem_req          = ($urandom_range(0, 99) < 30);
      mem_ready        = ($urandom_range(0, 99) < 60);
      step(1);
    end

    // Saturation: frozen block stalls for more than 2^16 cycles
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    repeat (65540) step(0);
    step(1);
    chk("stall_sat", stall_cnt, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
